wb_port_arbiter: RTL and testbench

//   Shares the single register-file write port between two writeback requesters:
//   R0 = ALU result path, R1 = multi-cycle unit (mult/div).

---
 rtl/wb_arb_pkg.sv | 18 +
 rtl/wb_data_mux.sv | 19 +
 rtl/wb_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the writeback port arbiter.
//   state_t  : arbiter FSM state (requester granted in the previous cycle)
//   SEL_R0/1 : writeback mux select encodings (0 = ALU path, 1 = mult/div)
//   REG_ZERO : architectural zero register; writes to it are suppressed
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic SEL_R0 = 1'b0;
  localparam logic SEL_R1 = 1'b1;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/wb_data_mux.sv
// 2:1 select of a packed {addr,data} writeback word.
// Ports:
//   sel  in   1               0 selects in0, 1 selects in1
//   in0  in   ADDR_W+DATA_W   R0 {addr,data}
//   in1  in   ADDR_W+DATA_W   R1 {addr,data}
//   out  out  ADDR_W+DATA_W   selected {addr,data} (combinational)
module wb_data_mux #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     sel,
  input  logic [ADDR_W+DATA_W-1:0] in0,
  input  logic [ADDR_W+DATA_W-1:0] in1,
  output logic [ADDR_W+DATA_W-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter with bounded hold sharing the register-file write port
// between the ALU result path (R0) and the multi-cycle unit (R1). Grants and
// acks are combinational; the write port is registered (1-cycle latency).
// Optional feature macro: WB_ARB_STATS_EN adds grant/conflict counters.
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   req0_i/addr0_i/data0_i  R0 request, held until ack0_o
//   req1_i/addr1_i/data1_i  R1 request, held until ack1_o
//   ack0_o, ack1_o          1-cycle accept pulses (never both)
//   sel_o                   source of the registered write (0=R0, 1=R1)
//   we_o, waddr_o, wdata_o  registered register-file write port
//   grant_cnt0_o/1_o        (WB_ARB_STATS_EN) accepted grants per requester
//   conflict_cnt_o          (WB_ARB_STATS_EN) cycles with both requesting
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] data0_i,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] data1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic              sel_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]       grant_cnt0_o,
  output logic [31:0]       grant_cnt1_o,
  output logic [31:0]       conflict_cnt_o
`endif
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  state_t            state;
  logic              rr_ptr;
  logic [HW-1:0]     hold_cnt;

  logic              gnt_vld;
  logic              gnt_sel;
  logic              same_req;
  logic [HW-1:0]     hold_nxt;
  logic [ADDR_W+DATA_W-1:0] mux_out;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_data;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_sel = SEL_R0;
    if (req0_i && req1_i) begin
      gnt_vld = 1'b1;
      case (state)
        GNT0:    gnt_sel = (hold_cnt < HOLD_MAX) ? SEL_R0 : SEL_R1;
        GNT1:    gnt_sel = (hold_cnt < HOLD_MAX) ? SEL_R1 : SEL_R0;
        default: gnt_sel = rr_ptr;
      endcase
    end else if (req0_i) begin
      gnt_vld = 1'b1;
      gnt_sel = SEL_R0;
    end else if (req1_i) begin
      gnt_vld = 1'b1;
      gnt_sel = SEL_R1;
    end
  end

  // Acks are suppressed during reset even though requests may still be high.
  assign ack0_o = gnt_vld && (gnt_sel == SEL_R0) && !reset;
  assign ack1_o = gnt_vld && (gnt_sel == SEL_R1) && !reset;

  always_comb begin
    same_req = ((state == GNT0) && (gnt_sel == SEL_R0)) ||
               ((state == GNT1) && (gnt_sel == SEL_R1));
    hold_nxt = '0;
    if (gnt_vld) begin
      if (!same_req)
        hold_nxt = HW'(1);
      else if (hold_cnt < HOLD_MAX)
        hold_nxt = hold_cnt + HW'(1);
      else
        hold_nxt = hold_cnt;
    end
  end

  wb_data_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mux (
    .sel (gnt_sel),
    .in0 ({addr0_i, data0_i}),
    .in1 ({addr1_i, data1_i}),
    .out (mux_out)
  );

  assign mux_addr = mux_out[ADDR_W+DATA_W-1:DATA_W];
  assign mux_data = mux_out[DATA_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      rr_ptr         <= SEL_R0;
      hold_cnt       <= '0;
      we_o           <= 1'b0;
      sel_o          <= SEL_R0;
      waddr_o        <= '0;
      wdata_o        <= '0;
`ifdef WB_ARB_STATS_EN
      grant_cnt0_o   <= '0;
      grant_cnt1_o   <= '0;
      conflict_cnt_o <= '0;
`endif
    end else begin
      hold_cnt <= hold_nxt;
      if (gnt_vld) begin
        state   <= (gnt_sel == SEL_R1) ? GNT1 : GNT0;
        rr_ptr  <= ~gnt_sel;
        // Writes to the zero register are acked but never reach the file.
        we_o    <= (mux_addr != ADDR_W'(REG_ZERO));
        sel_o   <= gnt_sel;
        waddr_o <= mux_addr;
        wdata_o <= mux_data;
      end else begin
        state   <= IDLE;
        we_o    <= 1'b0;
      end
`ifdef WB_ARB_STATS_EN
      if (ack0_o)
        grant_cnt0_o <= grant_cnt0_o + 32'd1;
      if (ack1_o)
        grant_cnt1_o <= grant_cnt1_o + 32'd1;
      if (req0_i && req1_i)
        conflict_cnt_o <= conflict_cnt_o + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: stimulus pushes the expected ack per
// cycle and the expected register-file writes; a negedge monitor pops and
// compares. Stats checks are compiled in with WB_ARB_STATS_EN.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [4:0]  addr0, addr1;
  logic [31:0] data0, data1;
  logic        ack0, ack1, sel, we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
`ifdef WB_ARB_STATS_EN
  logic [31:0] grant_cnt0, grant_cnt1, conflict_cnt;
`endif

  int errors = 0;
  int checks = 0;

  int          ack_q[$];
  logic [63:0] wr_q[$];

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .MAX_HOLD (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req0_i  (req0),
    .addr0_i (addr0),
    .data0_i (data0),
    .req1_i  (req1),
    .addr1_i (addr1),
    .data1_i (data1),
    .ack0_o  (ack0),
    .ack1_o  (ack1),
    .sel_o   (sel),
    .we_o    (we),
    .waddr_o (waddr),
    .wdata_o (wdata)
`ifdef WB_ARB_STATS_EN
    ,
    .grant_cnt0_o   (grant_cnt0),
    .grant_cnt1_o   (grant_cnt1),
    .conflict_cnt_o (conflict_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // exp: 0 = no ack, 1 = ack0, 2 = ack1
  task automatic step(input logic r0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic r1, input logic [4:0] a1, input logic [31:0] d1,
                      input int exp);
    req0 = r0; addr0 = a0; data0 = d0;
    req1 = r1; addr1 = a1; data1 = d1;
    ack_q.push_back(exp);
    if (exp == 1 && a0 != 5'd0) wr_q.push_back(64'({1'b0, a0, d0}));
    if (exp == 2 && a1 != 5'd0) wr_q.push_back(64'({1'b1, a1, d1}));
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 0);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Monitor: compares acks every scheduled cycle and every write the DUT issues.
  always @(negedge clk) begin
    int e;
    int a;
    if (ack_q.size() > 0) begin
      e = ack_q.pop_front();
      a = ack1 ? 2 : (ack0 ? 1 : 0);
      check("ack", 64'(a), 64'(e));
    end
    if (ack0 || ack1)
      check("ack_exclusive", 64'(ack0 & ack1), 64'd0);
    if (we) begin
      if (wr_q.size() == 0)
        check("unexpected_write", 64'({sel, waddr, wdata}), 64'd0);
      else
        check("write", 64'({sel, waddr, wdata}), wr_q.pop_front());
    end
  end

  int exp2[10] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};
  int exp3[11] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 2};

  initial begin
    reset = 1'b1;
    req0 = 1'b0; addr0 = '0; data0 = '0;
    req1 = 1'b0; addr1 = '0; data1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack0", 64'(ack0), 64'd0);
    check("rst_ack1", 64'(ack1), 64'd0);
    check("rst_we", 64'(we), 64'd0);
    check("rst_sel", 64'(sel), 64'd0);
    check("rst_waddr", 64'(waddr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    reset = 1'b0;

    // Single R0 request
    step(1'b1, 5'd3, 32'h0000_00AA, 1'b0, 5'd0, 32'd0, 1);
    idle();

    // R1 write to $0: acked, no write
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, 2);
    idle();

    // Both held from reset release: blocks of MAX_HOLD grants
    reset_pulse();
    for (int i = 0; i < 10; i++)
      step(1'b1, 5'd1, 32'h1000 + 32'(i), 1'b1, 5'd2, 32'h2000 + 32'(i), exp2[i]);
    idle();

    // R0 held 10 cycles, R1 joins at cycle 2 and outlasts it
    reset_pulse();
    for (int i = 0; i < 11; i++)
      step(i < 10, 5'd5, 32'h5500 + 32'(i), i >= 2, 5'd6, 32'h6600 + 32'(i), exp3[i]);
    idle();

    // Reset on a grant cycle: rr pointer points at R1 beforehand
    step(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1);
    idle();
    req0 = 1'b1; addr0 = 5'd7; data0 = 32'h77;
    req1 = 1'b1; addr1 = 5'd8; data1 = 32'h88;
    ack_q.push_back(0);
    #2 reset = 1'b1;
    @(negedge clk); #1;
    check("rstmid_ack0", 64'(ack0), 64'd0);
    check("rstmid_ack1", 64'(ack1), 64'd0);
    check("rstmid_we", 64'(we), 64'd0);
    check("rstmid_waddr", 64'(waddr), 64'd0);
    check("rstmid_wdata", 64'(wdata), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 1);
    idle();

`ifdef WB_ARB_STATS_EN
    reset_pulse();
    check("stat_rst_g0", 64'(grant_cnt0), 64'd0);
    check("stat_rst_g1", 64'(grant_cnt1), 64'd0);
    check("stat_rst_cf", 64'(conflict_cnt), 64'd0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd10, 32'hA0 + 32'(i), 1'b1, 5'd11, 32'hB0, 1);
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'd12, 32'hC0 + 32'(i), 1'b0, 5'd0, 32'd0, 1);
    for (int i = 0; i < 5; i++)
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hD0 + 32'(i), 2);
    idle();
    check("stat_g0", 64'(grant_cnt0), 64'd7);
    check("stat_g1", 64'(grant_cnt1), 64'd5);
    check("stat_cf", 64'(conflict_cnt), 64'd3);
    reset_pulse();
    check("stat_clr_g0", 64'(grant_cnt0), 64'd0);
    check("stat_clr_g1", 64'(grant_cnt1), 64'd0);
    check("stat_clr_cf", 64'(conflict_cnt), 64'd0);
`endif

    idle();
    idle();
    check("ack_q_drained", 64'(ack_q.size()), 64'd0);
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
